// File: rtl/eth_txarb_rr_if.sv
// Bundle between the per-source TX FIFOs, the arbiter and the MAC-side TX FIFO.
// The master side is the arbiter. The slave side is the FIFO environment around it.
interface eth_txarb_rr_if #(
   parameter int N_CH   = 2,
   parameter int DATA_W = 74
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH*DATA_W-1:0] fifo_dout;
   logic [N_CH-1:0]        fifo_empty;
   logic [N_CH-1:0]        fifo_rd_en;
   logic [DATA_W-1:0]      din;
   logic                   full;
   logic                   wr_en;
   logic [CH_W-1:0]        grant;
   logic                   busy;

   modport master (
      input  fifo_dout, fifo_empty, full,
      output fifo_rd_en, din, wr_en, grant, busy
   );

   modport slave (
      output fifo_dout, fifo_empty, full,
      input  fifo_rd_en, din, wr_en, grant, busy
   );
endinterface

// File: rtl/eth_txarb_rr.sv
// N-channel whole-packet arbiter for the Ethernet TX path.
// It merges FWFT source FIFOs into one destination FIFO using round-robin or
// fixed priority. A packet, once granted, owns the output until its tlast word
// has been popped. Empty or full mid-packet stalls the transfer in place.
module eth_txarb_rr #(
   parameter int N_CH      = 2,
   parameter int DATA_W    = 74,
   parameter int TLAST_BIT = 1,
   parameter int RR_MODE   = 1
) (
   input  logic            clk,
   input  logic            rst,
   eth_txarb_rr_if.master  bus
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [CH_W-1:0]   ptr;
   logic [CH_W-1:0]   pick;
   logic [CH_W-1:0]   grant_r;
   logic              start;
   logic              pop;
   logic              tlast;
   logic [DATA_W-1:0] word_sel;
   logic [DATA_W-1:0] din_p1;
   logic              wr_en_p1;

   // Successor of a channel index, wrapping at N_CH.
   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
      if (int'(ch) >= N_CH - 1)
         return '0;
      return ch + 1'b1;
   endfunction

   // Arbitration starts only when the destination has room and someone is waiting.
   assign start = !bus.full && !(&bus.fifo_empty);

   // A pop is allowed only while we own a channel that has data and room exists.
   // Reset gates it so an aborted packet leaves its remaining words in the source.
   assign pop   = (state == XFER) && !rst && !bus.fifo_empty[grant_r] && !bus.full;
   assign tlast = word_sel[TLAST_BIT];

   // Word offered by the currently granted channel.
   always_comb begin
      word_sel = bus.fifo_dout[int'(grant_r)*DATA_W +: DATA_W];
   end

   // Choose a channel: search upward from ptr in RR mode, or from channel 0 in priority mode.
   // The loop runs downward so the nearest non-empty channel is the last one assigned.
   always_comb begin
      int idx;
      idx  = 0;
      pick = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         idx = (RR_MODE != 0) ? int'(ptr) + i : i;
         if (idx >= N_CH)
            idx = idx - N_CH;
         if (!bus.fifo_empty[idx])
            pick = CH_W'(idx);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM next-state logic: leave IDLE on a grant, and leave XFER on the tlast pop.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = XFER;
         XFER:    if (pop && tlast) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: a one-hot pop strobe towards the granted source, and the busy flag.
   always_comb begin
      bus.fifo_rd_en = '0;
      if (pop)
         bus.fifo_rd_en[grant_r] = 1'b1;
      bus.busy = (state == XFER);
   end

   // Grant, round-robin pointer and the registered write towards the destination FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_r  <= '0;
         ptr      <= '0;
         din_p1   <= '0;
         wr_en_p1 <= 1'b0;
      end else begin
         wr_en_p1 <= pop;
         if (pop)
            din_p1 <= word_sel;
         if (state == IDLE && start)
            grant_r <= pick;
         if (pop && tlast && RR_MODE != 0)
            ptr <= next_ch(grant_r);
      end
   end

   assign bus.din   = din_p1;
   assign bus.wr_en = wr_en_p1;
   assign bus.grant = grant_r;
endmodule

// File: tb/tb_eth_txarb_rr.sv
// Directed bench for eth_txarb_rr.
// Instance A has 4 channels in RR mode. Instance B has 2 channels in priority mode.
// Instance C has 2 channels in RR mode.
// The source FIFOs are FWFT queues that the bench pops whenever the DUT strobed rd_en.
module tb_eth_txarb_rr;
   localparam int DW = 16;

   logic clk;
   logic rst;

   int n_cmp = 0;
   int n_mis = 0;
   int last0;
   int firstg1;
   int nxt0;

   logic [DW-1:0] qa [4][$];
   logic [DW-1:0] qb [2][$];
   logic [DW-1:0] qc [2][$];

   eth_txarb_rr_if #(.N_CH(4), .DATA_W(DW)) ia ();
   eth_txarb_rr_if #(.N_CH(2), .DATA_W(DW)) ib ();
   eth_txarb_rr_if #(.N_CH(2), .DATA_W(DW)) ic ();

   eth_txarb_rr #(.N_CH(4), .DATA_W(DW), .TLAST_BIT(1), .RR_MODE(1)) u_a (
      .clk(clk), .rst(rst), .bus(ia));
   eth_txarb_rr #(.N_CH(2), .DATA_W(DW), .TLAST_BIT(1), .RR_MODE(0)) u_b (
      .clk(clk), .rst(rst), .bus(ib));
   eth_txarb_rr #(.N_CH(2), .DATA_W(DW), .TLAST_BIT(1), .RR_MODE(1)) u_c (
      .clk(clk), .rst(rst), .bus(ic));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Word format: channel in [15:12], sequence number in [11:4], tlast in bit 1.
   function automatic logic [DW-1:0] mk(input int ch, input int k, input bit last);
      return DW'((ch << 12) | (k << 4) | (last ? 2 : 0));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < 4; i++) begin
         ia.fifo_empty[i] = (qa[i].size() == 0);
         ia.fifo_dout[i*DW +: DW] = (qa[i].size() != 0) ? qa[i][0] : '0;
      end
      for (int i = 0; i < 2; i++) begin
         ib.fifo_empty[i] = (qb[i].size() == 0);
         ib.fifo_dout[i*DW +: DW] = (qb[i].size() != 0) ? qb[i][0] : '0;
         ic.fifo_empty[i] = (qc[i].size() == 0);
         ic.fifo_dout[i*DW +: DW] = (qc[i].size() != 0) ? qc[i][0] : '0;
      end
   endtask

   task automatic settle();
      refresh();
      #1;
   endtask

   // One clock: the rd_en seen before the edge decides which model FIFOs pop.
   task automatic clk_step();
      logic [3:0] ca;
      logic [1:0] cb;
      logic [1:0] cc;
      ca = ia.fifo_rd_en;
      cb = ib.fifo_rd_en;
      cc = ic.fifo_rd_en;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         if (ca[i] && qa[i].size() != 0) void'(qa[i].pop_front());
      for (int i = 0; i < 2; i++) begin
         if (cb[i] && qb[i].size() != 0) void'(qb[i].pop_front());
         if (cc[i] && qc[i].size() != 0) void'(qc[i].pop_front());
      end
      refresh();
      @(negedge clk);
   endtask

   initial begin
      // Reset held for 3 clocks while every source is non-empty.
      rst = 1'b1;
      ia.full = 1'b0;
      ib.full = 1'b0;
      ic.full = 1'b0;
      for (int c = 0; c < 4; c++) qa[c].push_back(mk(c, 0, 1'b1));
      for (int c = 0; c < 2; c++) begin
         qb[c].push_back(mk(c, 0, 1'b1));
         qc[c].push_back(mk(c, 0, 1'b1));
      end
      settle();
      for (int k = 0; k < 3; k++) begin
         clk_step();
         chk("rst_rd_en", 32'(ia.fifo_rd_en), 0);
         chk("rst_wr_en", 32'(ia.wr_en), 0);
         chk("rst_din",   32'(ia.din), 0);
         chk("rst_grant", 32'(ia.grant), 0);
         chk("rst_busy",  32'(ia.busy), 0);
      end
      rst = 1'b0;
      settle();
      chk("rel_rd_en_idle", 32'(ia.fifo_rd_en), 0);
      clk_step();
      chk("rel_busy",  32'(ia.busy), 1);
      chk("rel_grant", 32'(ia.grant), 0);
      chk("rel_rd_en", 32'(ia.fifo_rd_en), 32'h1);
      for (int p = 0; p < 4; p++) begin
         if (p != 0) begin
            clk_step();
            chk("drain_grant", 32'(ia.grant), p);
         end
         clk_step();
         chk("drain_wr_en", 32'(ia.wr_en), 1);
         chk("drain_din",   32'(ia.din), 32'(mk(p, 0, 1'b1)));
      end
      clk_step();
      chk("drain_end_wr", 32'(ia.wr_en), 0);
      chk("drain_end_busy", 32'(ia.busy), 0);
      clk_step();

      // A single 3-word packet on ch1 of A.
      qa[1].push_back(16'h00A0);
      qa[1].push_back(16'h00A1);
      qa[1].push_back(16'h00A2);
      settle();
      chk("pkt_idle_rd_en", 32'(ia.fifo_rd_en), 0);
      clk_step();
      chk("pkt_grant", 32'(ia.grant), 1);
      chk("pkt_busy",  32'(ia.busy), 1);
      chk("pkt_rd_en", 32'(ia.fifo_rd_en), 32'h2);
      chk("pkt_wr0",   32'(ia.wr_en), 0);
      clk_step();
      chk("pkt_w1_wr", 32'(ia.wr_en), 1);
      chk("pkt_w1",    32'(ia.din), 32'h00A0);
      clk_step();
      chk("pkt_w2_wr", 32'(ia.wr_en), 1);
      chk("pkt_w2",    32'(ia.din), 32'h00A1);
      clk_step();
      chk("pkt_w3_wr", 32'(ia.wr_en), 1);
      chk("pkt_w3",    32'(ia.din), 32'h00A2);
      chk("pkt_idle",  32'(ia.busy), 0);
      clk_step();
      chk("pkt_gap_wr", 32'(ia.wr_en), 0);
      chk("pkt_din_hold", 32'(ia.din), 32'h00A2);
      // The pointer should now sit at 2, so ch2 beats ch0.
      qa[0].push_back(mk(0, 1, 1'b1));
      qa[2].push_back(mk(2, 1, 1'b1));
      settle();
      clk_step();
      chk("ptr_grant_ch2", 32'(ia.grant), 2);
      clk_step();
      chk("ptr_din_ch2", 32'(ia.din), 32'(mk(2, 1, 1'b1)));
      clk_step();
      chk("ptr_grant_wrap", 32'(ia.grant), 0);
      clk_step();
      chk("ptr_din_ch0", 32'(ia.din), 32'(mk(0, 1, 1'b1)));
      clk_step();

      // RR fairness on C: 4 single-word packets per channel.
      for (int k = 0; k < 4; k++) begin
         qc[0].push_back(mk(0, k, 1'b1));
         qc[1].push_back(mk(1, k, 1'b1));
      end
      settle();
      for (int s = 1; s <= 17; s++) begin
         clk_step();
         if (s % 2 == 0) begin
            chk("rr_wr_en", 32'(ic.wr_en), 1);
            chk("rr_din", 32'(ic.din), 32'(mk((s/2 - 1) % 2, (s/2 - 1) / 2, 1'b1)));
         end else begin
            chk("rr_gap", 32'(ic.wr_en), 0);
            if (s <= 15)
               chk("rr_grant", 32'(ic.grant), ((s - 1) / 2) % 2);
         end
      end

      // Priority on B: full holds arbitration off, and ch0 starves ch1 while it has data.
      ib.full = 1'b1;
      qb[1].push_back(mk(1, 9, 1'b1));
      settle();
      clk_step();
      clk_step();
      chk("full_idle_busy", 32'(ib.busy), 0);
      chk("full_idle_rd_en", 32'(ib.fifo_rd_en), 0);
      qb[0].push_back(mk(0, 0, 1'b1));
      qb[0].push_back(mk(0, 1, 1'b1));
      nxt0 = 2;
      ib.full = 1'b0;
      settle();
      for (int s = 0; s < 10; s++) begin
         clk_step();
         if (qb[0].size() < 2) begin
            qb[0].push_back(mk(0, nxt0, 1'b1));
            nxt0++;
         end
         settle();
         chk("prio_no_ch1_pop", 32'(ib.fifo_rd_en[1]), 0);
         chk("prio_grant_ch0", 32'(ib.grant), 0);
      end
      last0 = -1;
      firstg1 = -1;
      for (int s = 0; s < 20 && firstg1 < 0; s++) begin
         clk_step();
         if (ib.wr_en && ib.din[15:12] == 4'h0) last0 = s;
         if (ib.grant == 1'b1) firstg1 = s;
      end
      chk("prio_ch1_first_idle", firstg1, last0 + 1);
      clk_step();
      chk("prio_ch1_wr", 32'(ib.wr_en), 1);
      chk("prio_ch1_din", 32'(ib.din), 32'(mk(1, 9, 1'b1)));
      clk_step();

      // Stall mid-packet on A ch3: full after word 2, then source empty after word 3.
      qa[3].push_back(mk(3, 0, 1'b0));
      qa[3].push_back(mk(3, 1, 1'b0));
      qa[3].push_back(mk(3, 2, 1'b0));
      qa[0].push_back(mk(0, 5, 1'b1));
      settle();
      clk_step();
      chk("stall_grant", 32'(ia.grant), 3);
      chk("stall_rd_en", 32'(ia.fifo_rd_en), 32'h8);
      clk_step();
      chk("stall_w0", 32'(ia.din), 32'(mk(3, 0, 1'b0)));
      clk_step();
      chk("stall_w1", 32'(ia.din), 32'(mk(3, 1, 1'b0)));
      ia.full = 1'b1;
      settle();
      chk("full_rd_en_now", 32'(ia.fifo_rd_en), 0);
      for (int s = 0; s < 3; s++) begin
         clk_step();
         chk("full_rd_en", 32'(ia.fifo_rd_en), 0);
         chk("full_wr_en", 32'(ia.wr_en), 0);
         chk("full_grant", 32'(ia.grant), 3);
      end
      ia.full = 1'b0;
      settle();
      chk("full_release_rd_en", 32'(ia.fifo_rd_en), 32'h8);
      clk_step();
      chk("stall_w2_wr", 32'(ia.wr_en), 1);
      chk("stall_w2", 32'(ia.din), 32'(mk(3, 2, 1'b0)));
      chk("empty_no_pop", 32'(ia.fifo_rd_en), 0);
      for (int s = 0; s < 4; s++) begin
         clk_step();
         chk("empty_rd_en", 32'(ia.fifo_rd_en), 0);
         chk("empty_grant", 32'(ia.grant), 3);
         chk("empty_busy",  32'(ia.busy), 1);
         chk("empty_wr_en", 32'(ia.wr_en), 0);
      end
      qa[3].push_back(mk(3, 3, 1'b0));
      qa[3].push_back(mk(3, 4, 1'b1));
      settle();
      clk_step();
      chk("stall_w3", 32'(ia.din), 32'(mk(3, 3, 1'b0)));
      clk_step();
      chk("stall_w4", 32'(ia.din), 32'(mk(3, 4, 1'b1)));
      chk("stall_done_busy", 32'(ia.busy), 0);
      clk_step();
      chk("stall_next_grant", 32'(ia.grant), 0);
      clk_step();
      chk("stall_next_din", 32'(ia.din), 32'(mk(0, 5, 1'b1)));
      clk_step();

      // Reset after word 2 of a 4-word packet on A ch0.
      for (int k = 0; k < 4; k++) qa[0].push_back(mk(0, k + 8, k == 3));
      settle();
      clk_step();
      chk("mrst_busy", 32'(ia.busy), 1);
      clk_step();
      chk("mrst_x0", 32'(ia.din), 32'(mk(0, 8, 1'b0)));
      clk_step();
      chk("mrst_x1", 32'(ia.din), 32'(mk(0, 9, 1'b0)));
      rst = 1'b1;
      settle();
      chk("mrst_rd_en_now", 32'(ia.fifo_rd_en), 0);
      clk_step();
      chk("mrst_wr_en", 32'(ia.wr_en), 0);
      chk("mrst_din",   32'(ia.din), 0);
      chk("mrst_grant", 32'(ia.grant), 0);
      chk("mrst_busy0", 32'(ia.busy), 0);
      chk("mrst_left",  qa[0].size(), 2);
      rst = 1'b0;
      settle();
      clk_step();
      chk("mrst_regrant", 32'(ia.grant), 0);
      chk("mrst_rd_en", 32'(ia.fifo_rd_en), 32'h1);
      clk_step();
      chk("mrst_x2", 32'(ia.din), 32'(mk(0, 10, 1'b0)));
      clk_step();
      chk("mrst_x3", 32'(ia.din), 32'(mk(0, 11, 1'b1)));
      chk("mrst_end_busy", 32'(ia.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
